// File: rtl/alu_pkg.sv
// Shared encodings for alu_mc: opcodes, branch conditions, FSM states and the branch evaluator.
package alu_pkg;

    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_ROL = 4'b0101;
    localparam logic [3:0] OP_SRL = 4'b0110;
    localparam logic [3:0] OP_SRA = 4'b0111;
    localparam logic [3:0] OP_AND = 4'b1000;
    localparam logic [3:0] OP_OR  = 4'b1001;
    localparam logic [3:0] OP_XOR = 4'b1010;
    localparam logic [3:0] OP_NOR = 4'b1011;

    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_MULH = 5'b10001;
    localparam logic [4:0] OP_DIV  = 5'b10010;
    localparam logic [4:0] OP_REM  = 5'b10011;

    localparam logic [2:0] BR_NEVER  = 3'b000;
    localparam logic [2:0] BR_EQ     = 3'b001;
    localparam logic [2:0] BR_NE     = 3'b010;
    localparam logic [2:0] BR_LT     = 3'b011;
    localparam logic [2:0] BR_GE     = 3'b100;
    localparam logic [2:0] BR_LTU    = 3'b101;
    localparam logic [2:0] BR_GEU    = 3'b110;
    localparam logic [2:0] BR_ALWAYS = 3'b111;

    typedef enum logic [2:0] {IDLE, EXEC1, MUL, DIV, DONE} state_t;

    function automatic logic br_eval(input logic [2:0] br, input logic eq,
                                     input logic lt, input logic ltu);
        logic res;
        case (br)
            BR_NEVER: res = 1'b0;
            BR_EQ:    res = eq;
            BR_NE:    res = !eq;
            BR_LT:    res = lt;
            BR_GE:    res = !lt;
            BR_LTU:   res = ltu;
            BR_GEU:   res = !ltu;
            default:  res = 1'b1;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/seq_muldiv.sv
// Iterative unsigned multiply (shift-add) / restoring divide, one bit per cycle.
// The 2*WIDTH accumulator holds {high, low} for MUL and {remainder, quotient} for DIV.
module seq_muldiv
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_run,
    input  logic             i_div,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_done_c,
    output logic [WIDTH-1:0] o_lo_c,
    output logic [WIDTH-1:0] o_hi_c
);

    localparam int unsigned SHW = $clog2(WIDTH);
    localparam int unsigned CW  = SHW + 1;

    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] w_acc_nxt;
    logic [WIDTH-1:0]   r_opb;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_diff;

    // One iteration step; diff bit WIDTH set means the trial subtraction went negative.
    always_comb begin
        w_sum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_opb};
        w_diff    = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_opb};
        w_acc_nxt = r_acc;
        if (i_div) begin
            if (!w_diff[WIDTH]) begin
                w_acc_nxt = {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
            end else begin
                w_acc_nxt = {r_acc[2*WIDTH-2:0], 1'b0};
            end
        end else if (r_acc[0]) begin
            w_acc_nxt = {w_sum, r_acc[WIDTH-1:1]};
        end else begin
            w_acc_nxt = {1'b0, r_acc[2*WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
            r_opb <= '0;
            r_cnt <= '0;
        end else if (i_start) begin
            r_acc <= {{WIDTH{1'b0}}, i_a};
            r_opb <= i_b;
            r_cnt <= '0;
        end else if (i_run) begin
            r_acc <= w_acc_nxt;
            if (r_cnt != CW'(WIDTH)) begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_done_c = i_run && (r_cnt == CW'(WIDTH - 1));
    assign o_lo_c   = w_acc_nxt[WIDTH-1:0];
    assign o_hi_c   = w_acc_nxt[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/alu_mc.sv
// Handshaked ALU: single-cycle shift/logic/add ops plus iterative MUL/DIV, with branch compare.
module alu_mc
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic [2:0]       br,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             check,
    output logic             div_zero
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [4:0]         r_op;
    logic [WIDTH-1:0]   r_result;
    logic               r_in_ready;
    logic               r_out_valid;
    logic               r_check;
    logic               r_div_zero;
    logic               w_accept;
    logic               w_is_mc;
    logic               w_is_div;
    logic               w_dz;
    logic               w_start;
    logic               w_run;
    logic               w_run_div;
    logic               w_md_done;
    logic               w_br;
    logic [WIDTH-1:0]   w_md_lo;
    logic [WIDTH-1:0]   w_md_hi;
    logic [WIDTH-1:0]   w_single;
    logic [SHW-1:0]     w_sh;
    logic [2*WIDTH-1:0] w_rol;

    assign w_accept  = in_valid && (r_state == IDLE);
    assign w_is_mc   = (op[4:2] == OP_MUL[4:2]);
    assign w_is_div  = (op[4:1] == OP_DIV[4:1]);
    assign w_dz      = w_is_div && (b == '0);
    assign w_run     = (r_state == MUL) || (r_state == DIV);
    assign w_run_div = (r_state == DIV);
    assign w_br      = br_eval(br, a == b, $signed(a) < $signed(b), a < b);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Divide by zero skips iteration entirely and lands in DONE on the accept edge.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    if (w_dz) begin
                        w_state_nxt = DONE;
                    end else if (w_is_mc) begin
                        w_state_nxt = w_is_div ? DIV : MUL;
                        w_start     = 1'b1;
                    end else begin
                        w_state_nxt = EXEC1;
                    end
                end
            end
            EXEC1:    w_state_nxt = DONE;
            MUL, DIV: if (w_md_done) w_state_nxt = DONE;
            DONE:     if (out_ready) w_state_nxt = IDLE;
            default:  w_state_nxt = IDLE;
        endcase
    end

    assign w_sh  = r_b[SHW-1:0];
    assign w_rol = {r_a, r_a} << w_sh;

    // Single-cycle datapath on the latched operands; reserved multi-cycle codes yield 0.
    always_comb begin
        w_single = '0;
        casez (r_op[3:0])
            OP_SLL:  w_single = r_a << w_sh;
            OP_ROL:  w_single = w_rol[2*WIDTH-1:WIDTH];
            OP_SRL:  w_single = r_a >> w_sh;
            OP_SRA:  w_single = WIDTH'($signed(r_a) >>> w_sh);
            OP_AND:  w_single = r_a & r_b;
            OP_OR:   w_single = r_a | r_b;
            OP_XOR:  w_single = r_a ^ r_b;
            OP_NOR:  w_single = ~(r_a | r_b);
            4'b11?0: w_single = r_a + r_b;
            4'b11?1: w_single = r_a + ~r_b + WIDTH'(1);
            default: w_single = '0;
        endcase
        if (r_op[4]) begin
            w_single = '0;
        end
    end

    seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk      (clk),
        .rst      (rst),
        .i_start  (w_start),
        .i_run    (w_run),
        .i_div    (w_run_div),
        .i_a      (a),
        .i_b      (b),
        .o_done_c (w_md_done),
        .o_lo_c   (w_md_lo),
        .o_hi_c   (w_md_hi)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= '0;
            r_result    <= '0;
            r_check     <= 1'b0;
            r_div_zero  <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_in_ready  <= (w_state_nxt == IDLE);
            r_out_valid <= (w_state_nxt == DONE);
            if (w_accept) begin
                r_a        <= a;
                r_b        <= b;
                r_op       <= op;
                r_check    <= w_br;
                r_div_zero <= w_dz;
                if (w_dz) begin
                    r_result <= (op == OP_REM) ? a : '1;
                end
            end
            if (r_state == EXEC1) begin
                r_result <= w_single;
            end
            if (w_md_done) begin
                r_result <= ((r_op == OP_MULH) || (r_op == OP_REM)) ? w_md_hi : w_md_lo;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign check     = r_check;
    assign div_zero  = r_div_zero;

endmodule

// File: tb/tb_alu_mc.sv
// Randomised self-checking bench for alu_mc against an arithmetic reference model.
module tb_alu_mc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [4:0]  op = '0;
    logic [2:0]  br = '0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] result;
    logic        check;
    logic        div_zero;

    int          n_tests = 0;
    int          n_fail = 0;
    logic [15:0] exp_res = '0;
    logic        exp_chk = 1'b0;
    logic        exp_dz = 1'b0;
    logic        exp_armed = 1'b0;

    alu_mc #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .br        (br),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .check     (check),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] model_res(input logic [4:0] o, input logic [15:0] x,
                                              input logic [15:0] y);
        int unsigned ux = 32'(x);
        int unsigned uy = 32'(y);
        int unsigned sh = 32'(y[3:0]);
        int          sx = {{16{x[15]}}, x};
        logic [31:0] r;
        if (o[4]) begin
            case (o)
                5'b10000: r = ux * uy;
                5'b10001: r = (ux * uy) >> 16;
                5'b10010: r = (uy == 0) ? 32'h0000FFFF : ux / uy;
                5'b10011: r = (uy == 0) ? ux : ux % uy;
                default:  r = 32'd0;
            endcase
        end else begin
            case (o[3:2])
                2'd0: r = 32'd0;
                2'd1: case (o[1:0])
                    2'd0:    r = ux << sh;
                    2'd1:    r = (ux << sh) | (ux >> (16 - sh));
                    2'd2:    r = ux >> sh;
                    default: r = sx >>> sh;
                endcase
                2'd2: case (o[1:0])
                    2'd0:    r = ux & uy;
                    2'd1:    r = ux | uy;
                    2'd2:    r = ux ^ uy;
                    default: r = ~(ux | uy);
                endcase
                default: r = o[0] ? ux - uy : ux + uy;
            endcase
        end
        return r[15:0];
    endfunction

    function automatic logic model_br(input logic [2:0] c, input logic [15:0] x,
                                      input logic [15:0] y);
        int sx = {{16{x[15]}}, x};
        int sy = {{16{y[15]}}, y};
        case (c)
            3'd0:    return 1'b0;
            3'd1:    return x == y;
            3'd2:    return x != y;
            3'd3:    return sx < sy;
            3'd4:    return sx >= sy;
            3'd5:    return x < y;
            3'd6:    return x >= y;
            default: return 1'b1;
        endcase
    endfunction

    function automatic int model_lat(input logic [4:0] o, input logic [15:0] y);
        if (o[4:2] != 3'b100) return 2;
        if (o[1] && (y == 16'd0)) return 1;
        return 17;
    endfunction

    // Whenever a result is offered it must match the model for the op in flight.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (!exp_armed) begin
                chk("unexpected_out_valid", 32'(out_valid), 32'(exp_armed));
            end else begin
                chk("result", 32'(result), 32'(exp_res));
                chk("check", 32'(check), 32'(exp_chk));
                chk("div_zero", 32'(div_zero), 32'(exp_dz));
            end
        end
    end

    task automatic run_op(input logic [4:0] o, input logic [2:0] c, input logic [15:0] x,
                          input logic [15:0] y, input int hold, input int lit_res,
                          input int lit_chk);
        int edges;
        @(negedge clk);
        chk("in_ready_before_accept", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        op = o;
        br = c;
        a = x;
        b = y;
        @(posedge clk);
        exp_res   = model_res(o, x, y);
        exp_chk   = model_br(c, x, y);
        exp_dz    = (o[4:1] == 4'b1001) && (y == 16'd0);
        exp_armed = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        op = 5'($urandom);
        br = 3'($urandom);
        a  = 16'($urandom);
        b  = 16'($urandom);
        edges = 1;
        while (!out_valid && edges < 40) begin
            chk("in_ready_while_busy", 32'(in_ready), 32'd0);
            @(negedge clk);
            edges++;
        end
        chk("latency", 32'(edges), 32'(model_lat(o, y)));
        if (lit_res >= 0) chk("literal_result", 32'(result), 32'(lit_res));
        if (lit_chk >= 0) chk("literal_check", 32'(check), 32'(lit_chk));
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            op = 5'($urandom);
            a  = 16'($urandom);
            b  = 16'($urandom);
            @(negedge clk);
            chk("hold_out_valid", 32'(out_valid), 32'd1);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        exp_armed = 1'b0;
        chk("out_valid_after_handshake", 32'(out_valid), 32'd0);
        chk("in_ready_after_handshake", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [4:0]  r_o;
        logic [15:0] r_y;
        repeat (3) @(negedge clk);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_result", 32'(result), 32'd0);
        chk("reset_check", 32'(check), 32'd0);
        chk("reset_div_zero", 32'(div_zero), 32'd0);
        rst = 1'b0;

        run_op(5'b01100, 3'b011, 16'h7FFF, 16'h0001, 0, 32'h8000, 0);
        run_op(5'b01101, 3'b000, 16'h0003, 16'h0005, 0, 32'hFFFE, 0);
        run_op(5'b00111, 3'b001, 16'h8000, 16'h0014, 0, 32'hF800, 0);
        run_op(5'b00101, 3'b111, 16'h8001, 16'h0001, 0, 32'h0003, 1);
        run_op(5'b00010, 3'b010, 16'h1234, 16'h5678, 0, 32'h0000, 1);
        run_op(5'b10001, 3'b110, 16'hFFFF, 16'hFFFF, 0, 32'hFFFE, 1);
        run_op(5'b10000, 3'b100, 16'hFFFF, 16'hFFFF, 0, 32'h0001, 1);
        run_op(5'b10010, 3'b101, 16'd100, 16'd7, 0, 14, 0);
        run_op(5'b10011, 3'b011, 16'd100, 16'd7, 0, 2, 0);
        run_op(5'b10010, 3'b001, 16'h1234, 16'h0000, 0, 32'hFFFF, 0);
        run_op(5'b10011, 3'b010, 16'h1234, 16'h0000, 0, 32'h1234, 1);
        run_op(5'b11010, 3'b000, 16'hABCD, 16'h0003, 0, 32'h0000, 0);
        run_op(5'b01010, 3'b001, 16'h5A5A, 16'h5A5A, 5, 32'h0000, 1);
        run_op(5'b01001, 3'b000, 16'h5A00, 16'h00A5, 0, 32'h5AA5, 0);

        // Reset in the middle of a divide abandons it without a result.
        @(negedge clk);
        in_valid = 1'b1;
        op = 5'b10010;
        a  = 16'd1000;
        b  = 16'd3;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midop_reset_out_valid", 32'(out_valid), 32'd0);
        chk("midop_reset_in_ready", 32'(in_ready), 32'd1);
        chk("midop_reset_result", 32'(result), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op(5'b01100, 3'b101, 16'd1, 16'd2, 0, 3, 1);

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 2) == 0) r_o = {3'b100, 2'($urandom)};
            else r_o = 5'($urandom);
            r_y = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
            run_op(r_o, 3'($urandom), 16'($urandom), r_y, $urandom_range(0, 3), -1, -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised, handshaked successor to the 16-bit single-cycle ALU. It keeps the 4-bit class/function opcode space (zero, shift, bitwise, add/sub) and the 3-bit branch-compare output, generalised to WIDTH bits. It adds iterative multiply and divide. It sits between the register-read stage and writeback, and its valid/ready handshake lets the core stall on multi-cycle ops.

## Interface
- WIDTH, 16: operand/result width; must be ≥4 and a power of two.
- SHW, $clog2(WIDTH): shift-amount bits taken from b.
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operation offered.
- in_ready  out  1  block can accept; high only in IDLE.
- op  in  5  op[4]=0: single-cycle class op[3:0]; op[4]=1: multi-cycle op.
- br  in  3  branch condition.
- a, b  in  WIDTH  operands.
- out_valid  out  1  result/check/div_zero valid; held until out_ready.
- out_ready  in  1  consumer takes result.
- result  out  WIDTH  registered result.
- check  out  1  registered branch outcome.
- div_zero  out  1  set with result when DIV/REM divisor was 0.

## Operation
- Single-cycle op[3:0]:
  - 00xx → 0.
  - 0100 SLL, 0101 ROL, 0110 SRL, 0111 SRA, all by b[SHW-1:0].
  - 1000 AND, 1001 OR, 1010 XOR, 1011 NOR.
  - 11x0 ADD, 11x1 SUB (a + ~b + 1), modulo 2^WIDTH.
- Multi-cycle (unsigned):
  - 10000 MUL low half, 10001 MULH high half of the 2·WIDTH product.
  - 10010 DIV quotient, 10011 REM remainder.
  - 101xx/11xxx reserved → result 0 via the single-cycle path.
- Branch, from a and b captured at accept:
  - 000 never, 001 EQ, 010 NE, 011 LT signed, 100 GE signed, 101 LTU, 110 GEU, 111 always.
  - check is independent of op.
- Operands, op and br are latched on accept (in_valid & in_ready). Later input changes are ignored.
- States:
  - IDLE → EXEC1 on single-cycle accept.
  - IDLE → MUL or DIV on multi-cycle accept.
  - EXEC1 → DONE after one cycle.
  - MUL/DIV → DONE when the iteration counter reaches WIDTH.
  - DONE → IDLE on out_ready.
- MUL: shift-add, one multiplier bit per cycle, 2·WIDTH accumulator.
- DIV: restoring, one quotient bit per cycle.
- Divisor 0: no iteration. Go straight to DONE with quotient all-ones, remainder = a, div_zero=1.
- div_zero is 0 for every other op.

## Timing
- Reset values: in_ready=1 (IDLE), out_valid=0, result=0, check=0, div_zero=0, counter=0, accumulators=0.
- Reset mid-operation abandons the op. Nothing is emitted.
- Latency from the accept edge to out_valid high:
  - single-cycle op: 2 edges (EXEC1, then DONE);
  - MUL/MULH/DIV/REM: WIDTH+1 edges;
  - divide-by-zero: 1 edge.
- out_valid, result, check and div_zero are registered and stable for the whole DONE period.
- Handshake completes on the edge where out_valid & out_ready.
- in_ready rises the cycle after that completion; no same-cycle re-accept.
- in_valid while in_ready=0 is ignored. The requester must hold its request.
- out_ready while out_valid=0 has no effect.
- Counter width SHW+1. It saturates at WIDTH and never wraps.

## Structure
- Package alu_pkg holds:
  - op encodings (single-cycle class/function, MUL/MULH/DIV/REM);
  - branch codes;
  - the state enum {IDLE, EXEC1, MUL, DIV, DONE}.
- Sub-module seq_muldiv holds the iterative multiply/divide datapath (accumulator, counter, done pulse).
- The top holds the FSM, the single-cycle datapath and the branch compare.

## Test plan
- WIDTH=16, ADD 0x7FFF+0x0001, br=011 → result 0x8000, check=0, out_valid exactly 2 edges after accept; SUB 0x0003−0x0005 → 0xFFFE.
- SRA 0x8000 by b=0x0014 (low 4 bits = 4) → 0xF800; ROL 0x8001 by 1 → 0x0003; op 00xx → 0x0000.
- MULH 0xFFFF·0xFFFF → 0xFFFE; MUL → 0x0001; out_valid 17 edges after accept, in_ready low throughout.
- DIV 100/7 → 14, REM → 2, div_zero=0; DIV 0x1234/0 → 0xFFFF, div_zero=1, 1 edge; REM x/0 → 0x1234.
- Hold out_ready=0 for 5 cycles after DONE → result/check/out_valid stable, in_ready=0, new in_valid ignored; release → in_ready=1 next cycle.
- Assert rst during DIV cycle 6 → out_valid=0, in_ready=1, result=0 immediately; next op BLTU a=1,b=2 → check=1.
